// File: rtl/alu_arbiter_if.sv
// Bundle of requester, shared-ALU and response signals for alu_arbiter.
// The slave modport is the arbiter; master is whatever drives requests and models the ALU.
interface alu_arbiter_if #(
  parameter int unsigned W  = 4,
  parameter int unsigned CW = 2
);
  logic [1:0]      req_valid;
  logic [1:0]      req_ready;
  logic [2*W-1:0]  req_a;
  logic [2*W-1:0]  req_b;
  logic [2*CW-1:0] req_c;
  logic [3:0]      req_op;
  logic [W-1:0]    alu_a;
  logic [W-1:0]    alu_b;
  logic [CW-1:0]   alu_c;
  logic [1:0]      alu_op;
  logic [W-1:0]    alu_ans;
  logic            rsp_valid;
  logic            rsp_id;
  logic [W-1:0]    rsp_data;
  logic            rsp_ready;
  logic            busy;
  logic [7:0]      op_count;

  modport master (
    output req_valid, req_a, req_b, req_c, req_op, alu_ans, rsp_ready,
    input  req_ready, alu_a, alu_b, alu_c, alu_op, rsp_valid, rsp_id, rsp_data, busy, op_count
  );

  modport slave (
    input  req_valid, req_a, req_b, req_c, req_op, alu_ans, rsp_ready,
    output req_ready, alu_a, alu_b, alu_c, alu_op, rsp_valid, rsp_id, rsp_data, busy, op_count
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// Each operation walks IDLE -> ISSUE -> RESP; the ALU sees only registered operands.
module alu_arbiter #(
  parameter int unsigned W  = 4,
  parameter int unsigned CW = 2
) (
  input logic         clk,
  input logic         reset,
  alu_arbiter_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StIssue, StResp} state_e;

  state_e        state_q;
  logic [W-1:0]  a_q, b_q, res_q;
  logic [CW-1:0] c_q;
  logic [1:0]    op_q;
  logic          id_q;
  logic          last_q;
  logic          rsp_valid_q;
  logic          busy_q;
  logic [7:0]    cnt_q;

  logic any_req;
  logic gnt;

  // Contention goes to whoever was not served last.
  always_comb begin
    any_req = |bus.req_valid;
    gnt     = 1'b0;
    if (bus.req_valid == 2'b10) begin
      gnt = 1'b1;
    end else if (bus.req_valid == 2'b11) begin
      gnt = ~last_q;
    end
    bus.req_ready = 2'b00;
    if (reset && (state_q == StIdle) && any_req) begin
      bus.req_ready = gnt ? 2'b10 : 2'b01;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      a_q         <= '0;
      b_q         <= '0;
      c_q         <= '0;
      op_q        <= '0;
      id_q        <= 1'b0;
      res_q       <= '0;
      last_q      <= 1'b1;
      rsp_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      cnt_q       <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (any_req) begin
            a_q     <= gnt ? bus.req_a[2*W-1:W]   : bus.req_a[W-1:0];
            b_q     <= gnt ? bus.req_b[2*W-1:W]   : bus.req_b[W-1:0];
            c_q     <= gnt ? bus.req_c[2*CW-1:CW] : bus.req_c[CW-1:0];
            op_q    <= gnt ? bus.req_op[3:2]      : bus.req_op[1:0];
            id_q    <= gnt;
            busy_q  <= 1'b1;
            state_q <= StIssue;
          end
        end
        StIssue: begin
          res_q       <= bus.alu_ans;
          rsp_valid_q <= 1'b1;
          state_q     <= StResp;
        end
        StResp: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            last_q      <= id_q;
            cnt_q       <= cnt_q + 8'd1;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.alu_a     = a_q;
  assign bus.alu_b     = b_q;
  assign bus.alu_c     = c_q;
  assign bus.alu_op    = op_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = id_q;
  assign bus.rsp_data  = res_q;
  assign bus.busy      = busy_q;
  assign bus.op_count  = cnt_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter with an adder standing in for the shared ALU.
module tb_alu_arbiter;

  logic clk;
  logic reset;

  alu_arbiter_if #(.W(4), .CW(2)) bus ();

  alu_arbiter #(.W(4), .CW(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  assign bus.alu_ans = bus.alu_a + bus.alu_b;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       id;
    logic [3:0] data;
  } exp_t;

  exp_t       sb[$];
  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_cnt;
  logic [3:0] exp_alu_a;
  logic [3:0] ta[2];
  logic [3:0] tb[2];
  logic [1:0] tc[2];
  logic [1:0] top[2];

  task automatic drive_operands();
    bus.req_a  = {ta[1], ta[0]};
    bus.req_b  = {tb[1], tb[0]};
    bus.req_c  = {tc[1], tc[0]};
    bus.req_op = {top[1], top[0]};
  endtask

  // One full operation; caller is 1 time unit after a negedge with the DUT in IDLE.
  task automatic run_op(input logic [1:0] vld, input logic g, input int stall, input bit hold);
    exp_t       e;
    logic [1:0] exp_rdy;
    drive_operands();
    bus.req_valid = vld;
    bus.rsp_ready = (stall == 0);
    exp_rdy = g ? 2'b10 : 2'b01;
    #1;
    checks++;
    if (bus.req_ready !== exp_rdy) begin
      errors++; $display("FAIL grant req_ready=%b expected=%b", bus.req_ready, exp_rdy);
    end
    checks++;
    if (bus.busy !== 1'b0 || bus.alu_a !== exp_alu_a) begin
      errors++; $display("FAIL idle_hold busy=%b alu_a=%h expected busy=0 alu_a=%h",
                         bus.busy, bus.alu_a, exp_alu_a);
    end
    e.id   = g;
    e.data = ta[g] + tb[g];
    sb.push_back(e);

    @(negedge clk);
    if (!hold) bus.req_valid = 2'b00;
    #1;
    checks++;
    if (bus.req_ready !== 2'b00 || bus.busy !== 1'b1 || bus.rsp_valid !== 1'b0) begin
      errors++; $display("FAIL issue_state req_ready=%b busy=%b rsp_valid=%b expected 00 1 0",
                         bus.req_ready, bus.busy, bus.rsp_valid);
    end
    checks++;
    if ({bus.alu_a, bus.alu_b, bus.alu_c, bus.alu_op} !== {ta[g], tb[g], tc[g], top[g]}) begin
      errors++; $display("FAIL alu_operands got=%h expected=%h",
                         {bus.alu_a, bus.alu_b, bus.alu_c, bus.alu_op},
                         {ta[g], tb[g], tc[g], top[g]});
    end
    exp_alu_a = ta[g];

    @(negedge clk);
    #1;
    checks++;
    if (bus.rsp_valid !== 1'b1) begin
      errors++; $display("FAIL rsp_latency rsp_valid=%b expected=1", bus.rsp_valid);
    end
    if (sb.size() == 0) begin
      checks++; errors++; $display("FAIL scoreboard_empty size=0 expected>0");
    end else begin
      e = sb.pop_front();
      checks++;
      if (bus.rsp_id !== e.id || bus.rsp_data !== e.data) begin
        errors++; $display("FAIL rsp_value id=%b data=%h expected id=%b data=%h",
                           bus.rsp_id, bus.rsp_data, e.id, e.data);
      end
    end
    for (int s = 0; s < stall; s++) begin
      checks++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== e.data || bus.req_ready !== 2'b00) begin
        errors++; $display("FAIL stall_hold cyc=%0d rsp_valid=%b data=%h req_ready=%b expected 1 %h 00",
                           s, bus.rsp_valid, bus.rsp_data, bus.req_ready, e.data);
      end
      @(negedge clk);
      #1;
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    #1;
    exp_cnt = exp_cnt + 8'd1;
    checks++;
    if (bus.op_count !== exp_cnt || bus.rsp_valid !== 1'b0) begin
      errors++; $display("FAIL complete op_count=%0d rsp_valid=%b expected %0d 0",
                         bus.op_count, bus.rsp_valid, exp_cnt);
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b0;
    sb.delete();
    exp_cnt   = 8'd0;
    exp_alu_a = 4'd0;
    #1;
  endtask

  task automatic release_reset();
    @(negedge clk);
    reset = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    bus.req_valid = 2'b11;
    bus.rsp_ready = 1'b0;
    ta = '{4'h5, 4'h6}; tb = '{4'h1, 4'h2}; tc = '{2'd1, 2'd2}; top = '{2'd3, 2'd2};
    drive_operands();
    apply_reset();
    checks++;
    if (bus.req_ready !== 2'b00 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL reset_ctrl req_ready=%b busy=%b expected 00 0", bus.req_ready, bus.busy);
    end
    checks++;
    if ({bus.rsp_valid, bus.rsp_id, bus.rsp_data, bus.op_count} !== 14'd0) begin
      errors++; $display("FAIL reset_rsp valid=%b id=%b data=%h count=%0d expected zeros",
                         bus.rsp_valid, bus.rsp_id, bus.rsp_data, bus.op_count);
    end
    checks++;
    if ({bus.alu_a, bus.alu_b, bus.alu_c, bus.alu_op} !== 12'd0) begin
      errors++; $display("FAIL reset_alu got=%h expected=0",
                         {bus.alu_a, bus.alu_b, bus.alu_c, bus.alu_op});
    end
    bus.req_valid = 2'b00;
    release_reset();
  endtask

  task automatic test_idle();
    bus.req_valid = 2'b00;
    bus.rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.op_count !== exp_cnt || bus.alu_a !== exp_alu_a) begin
      errors++; $display("FAIL idle_no_req busy=%b count=%0d alu_a=%h expected 0 %0d %h",
                         bus.busy, bus.op_count, bus.alu_a, exp_cnt, exp_alu_a);
    end
  endtask

  task automatic test_single();
    ta[0] = 4'h3; tb[0] = 4'h4; tc[0] = 2'd2; top[0] = 2'd1;
    run_op(2'b01, 1'b0, 0, 1'b0);
  endtask

  task automatic test_contention();
    ta[1] = 4'h9; tb[1] = 4'h8; tc[1] = 2'd1; top[1] = 2'd2;
    for (int i = 0; i < 4; i++) begin
      run_op(2'b11, ((i % 2) == 0) ? 1'b1 : 1'b0, 0, 1'b1);
    end
  endtask

  task automatic test_backpressure();
    ta[0] = 4'h5; tb[0] = 4'h5; ta[1] = 4'h5; tb[1] = 4'h5;
    run_op(2'b11, 1'b1, 5, 1'b1);
  endtask

  task automatic test_reset_in_resp();
    exp_t e;
    ta[0] = 4'h2; tb[0] = 4'h2;
    run_op(2'b01, 1'b0, 0, 1'b0);
    drive_operands();
    bus.req_valid = 2'b01;
    bus.rsp_ready = 1'b0;
    e.id = 1'b0; e.data = 4'h4;
    sb.push_back(e);
    @(negedge clk);
    bus.req_valid = 2'b11;
    @(negedge clk);
    #1;
    checks++;
    if (bus.rsp_valid !== 1'b1) begin
      errors++; $display("FAIL pre_reset_resp rsp_valid=%b expected=1", bus.rsp_valid);
    end
    reset = 1'b0;
    sb.delete();
    exp_cnt = 8'd0; exp_alu_a = 4'd0;
    #1;
    checks++;
    if (bus.rsp_valid !== 1'b0 || bus.busy !== 1'b0 || bus.op_count !== 8'd0 ||
        bus.req_ready !== 2'b00 || bus.rsp_data !== 4'd0) begin
      errors++; $display("FAIL reset_in_resp valid=%b busy=%b count=%0d rdy=%b data=%h expected zeros",
                         bus.rsp_valid, bus.busy, bus.op_count, bus.req_ready, bus.rsp_data);
    end
    release_reset();
    ta[1] = 4'h7; tb[1] = 4'h1;
    run_op(2'b11, 1'b0, 0, 1'b0);
  endtask

  task automatic test_wrap();
    apply_reset();
    release_reset();
    ta[0] = 4'hF; tb[0] = 4'h2; tc[0] = 2'd3; top[0] = 2'd0;
    for (int i = 0; i < 256; i++) begin
      run_op(2'b01, 1'b0, 0, 1'b0);
    end
    checks++;
    if (bus.op_count !== 8'd0) begin
      errors++; $display("FAIL wrap_count op_count=%0d expected=0", bus.op_count);
    end
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset         = 1'b1;
    bus.req_valid = 2'b00;
    bus.rsp_ready = 1'b0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_c     = '0;
    bus.req_op    = '0;
    exp_cnt       = 8'd0;
    exp_alu_a     = 4'd0;
    test_reset();
    test_idle();
    test_single();
    test_contention();
    test_backpressure();
    test_reset_in_resp();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
